// File: rtl/maj_bist_pkg.sv
// Shared types and helpers for the majority-gate self-test engine.
// Holds the FSM state encoding, the popcount helper and LFSR tap masks.
package maj_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_APPLY = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

    // Widest vector the popcount helper accepts, and its sum width.
    localparam int POP_MAX_W = 256;
    localparam int POP_SUM_W = 9;

    // Galois right-shift feedback masks: bit (t-1) set for each tap t.
    localparam logic [7:0]  TAPS8  = 8'hB8;
    localparam logic [15:0] TAPS16 = 16'hB400;
    localparam logic [31:0] TAPS32 = 32'h8020_0003;
    localparam logic [52:0] TAPS53 = 53'h18_0030_0000_0000;
    localparam logic [63:0] TAPS64 = 64'hD800_0000_0000_0000;

    // Counts the ones in the low w bits of v; callers zero-extend
    // their vector to POP_MAX_W and pass their real width as w.
    function automatic logic [POP_SUM_W-1:0] popcount(
        input logic [POP_MAX_W-1:0] v,
        input int unsigned          w
    );
        logic [POP_SUM_W-1:0] s;
        s = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            if (i < w) begin
                s = s + POP_SUM_W'(v[i]);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/maj_bist_vecgen.sv
// Test-vector register: seed load (zero seed -> 1 in LFSR mode),
// increment or Galois LFSR step.
// Ports: clk, rst (sync, active-high), load_i/step_i controls,
//        mode_i (0 inc, 1 LFSR, taken on load), seed_i, x_o.
module maj_bist_vecgen
    import maj_bist_pkg::*;
#(
    parameter int           N    = 53,
    parameter logic [N-1:0] TAPS = N'(TAPS53)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         step_i,
    input  logic         mode_i,
    input  logic [N-1:0] seed_i,
    output logic [N-1:0] x_o
);

    logic [N-1:0] x_q;
    logic [N-1:0] x_d;
    logic [N-1:0] lfsr_nxt;
    logic         mode_q;
    logic         mode_d;

    assign lfsr_nxt = (x_q >> 1) ^ (x_q[0] ? TAPS : '0);

    always_comb begin
        x_d    = x_q;
        mode_d = mode_q;
        if (load_i) begin
            mode_d = mode_i;
            // An all-zero LFSR state would lock up.
            if (mode_i && (seed_i == '0)) begin
                x_d = N'(1);
            end else begin
                x_d = seed_i;
            end
        end else if (step_i) begin
            if (mode_q) begin
                x_d = lfsr_nxt;
            end else begin
                x_d = x_q + N'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= '0;
            mode_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            mode_q <= mode_d;
        end
    end

    assign x_o = x_q;

endmodule

// File: rtl/maj_bist_engine.sv
// Self-test driver/checker for an N-input threshold gate netlist.
// Ports: clk, rst (sync, active-high); start/mode/num_vec/seed run
//        setup; x drives the gate, y_dut is its output; busy, done,
//        pass, err_cnt (saturating), first_fail_vec/_valid report.
module maj_bist_engine
    import maj_bist_pkg::*;
#(
    parameter int           N      = 53,
    parameter int           THRESH = 27,
    parameter int           CNT_W  = 32,
    parameter int           MISS_W = 16,
    parameter int           SETTLE = 1,
    parameter logic [N-1:0] TAPS   = N'(TAPS53)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [CNT_W-1:0]  num_vec,
    input  logic [N-1:0]      seed,
    output logic [N-1:0]      x,
    input  logic              y_dut,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISS_W-1:0] err_cnt,
    output logic [N-1:0]      first_fail_vec,
    output logic              first_fail_valid
);

    localparam int PC_W = $clog2(N + 1);
    localparam logic [PC_W-1:0] THR_V = PC_W'(THRESH);
    localparam logic [7:0] WAIT_INIT =
        (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;

    bist_state_e       state_q;
    bist_state_e       state_d;
    logic [CNT_W-1:0]  rem_q;
    logic [CNT_W-1:0]  rem_d;
    logic [7:0]        wcnt_q;
    logic [7:0]        wcnt_d;
    logic [MISS_W-1:0] err_q;
    logic [MISS_W-1:0] err_d;
    logic [N-1:0]      ffvec_q;
    logic [N-1:0]      ffvec_d;
    logic              ffv_q;
    logic              ffv_d;
    logic              pass_q;
    logic              pass_d;
    logic              ref_q;
    logic              ref_d;
    logic              vec_load;
    logic              vec_step;
    logic [PC_W-1:0]   pc;

    maj_bist_vecgen #(
        .N    (N),
        .TAPS (TAPS)
    ) u_vecgen (
        .clk    (clk),
        .rst    (rst),
        .load_i (vec_load),
        .step_i (vec_step),
        .mode_i (mode),
        .seed_i (seed),
        .x_o    (x)
    );

    assign pc = PC_W'(popcount(POP_MAX_W'(x), N));

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        wcnt_d   = wcnt_q;
        err_d    = err_q;
        ffvec_d  = ffvec_q;
        ffv_d    = ffv_q;
        pass_d   = pass_q;
        ref_d    = ref_q;
        vec_load = 1'b0;
        vec_step = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d  = num_vec;
                    err_d  = '0;
                    ffv_d  = 1'b0;
                    pass_d = 1'b0;
                    if (num_vec == '0) begin
                        state_d = ST_DONE;
                        pass_d  = 1'b1;
                    end else begin
                        vec_load = 1'b1;
                        state_d  = ST_APPLY;
                    end
                end
            end
            ST_APPLY: begin
                ref_d = (pc >= THR_V);
                if (SETTLE == 0) begin
                    state_d = ST_CHECK;
                end else begin
                    wcnt_d  = WAIT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 8'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    wcnt_d = wcnt_q - 8'd1;
                end
            end
            ST_CHECK: begin
                if (y_dut != ref_q) begin
                    if (err_q != {MISS_W{1'b1}}) begin
                        err_d = err_q + MISS_W'(1);
                    end
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = x;
                    end
                end
                rem_d = rem_q - CNT_W'(1);
                if (rem_d == '0) begin
                    // Result is final as DONE is entered, so pass is
                    // valid alongside the done pulse.
                    pass_d  = (err_d == '0);
                    state_d = ST_DONE;
                end else begin
                    vec_step = 1'b1;
                    state_d  = ST_APPLY;
                end
            end
            ST_DONE: begin
                pass_d  = (err_q == '0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            wcnt_q  <= '0;
            err_q   <= '0;
            ffvec_q <= '0;
            ffv_q   <= 1'b0;
            pass_q  <= 1'b0;
            ref_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            ffvec_q <= ffvec_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
            ref_q   <= ref_d;
        end
    end

    assign busy = (state_q == ST_APPLY) ||
                  (state_q == ST_WAIT)  ||
                  (state_q == ST_CHECK);
    assign done             = (state_q == ST_DONE);
    assign pass             = pass_q;
    assign err_cnt          = err_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_maj_bist_engine.sv
// Scoreboard bench for maj_bist_engine: directed runs push expected
// vectors and results; monitors pop and compare as the DUT presents them.
module tb_maj_bist_engine;

    localparam int N = 53;
    localparam logic [N-1:0] TAPS_TB = 53'h18_0030_0000_0000;

    typedef struct {
        int unsigned  cyc;
        bit           pass;
        int           err;
        bit           ffv;
        logic [N-1:0] ffvec;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [31:0]  num_vec;
    logic [N-1:0] seed;
    logic [N-1:0] x;
    logic         y_dut;
    logic         busy;
    logic         done;
    logic         pass;
    logic [15:0]  err_cnt;
    logic [N-1:0] ffvec;
    logic         ffv;

    logic         start4;
    logic [31:0]  num_vec4;
    logic [N-1:0] seed4;
    logic [N-1:0] x4;
    logic         y4;
    logic         busy4;
    logic         done4;
    logic         pass4;
    logic [3:0]   err4;
    logic [N-1:0] ffvec4;
    logic         ffv4;

    int          model;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          phase = 0;
    res_t        resq[$];
    res_t        res4q[$];
    logic [N-1:0] xq[$];
    res_t        rm;
    res_t        rm4;
    logic [N-1:0] xe;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate models: 0 correct (>=27), 1 faulty (>=26), 2 stuck at 1.
    always_comb begin
        y_dut = 1'b0;
        if (model == 2) y_dut = 1'b1;
        else if (model == 1) y_dut = ($countones(x) >= 26);
        else y_dut = ($countones(x) >= 27);
    end
    assign y4 = 1'b1;

    maj_bist_engine dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .mode             (mode),
        .num_vec          (num_vec),
        .seed             (seed),
        .x                (x),
        .y_dut            (y_dut),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_cnt          (err_cnt),
        .first_fail_vec   (ffvec),
        .first_fail_valid (ffv)
    );

    maj_bist_engine #(.MISS_W(4), .SETTLE(0)) dut4 (
        .clk              (clk),
        .rst              (rst),
        .start            (start4),
        .mode             (1'b0),
        .num_vec          (num_vec4),
        .seed             (seed4),
        .x                (x4),
        .y_dut            (y4),
        .busy             (busy4),
        .done             (done4),
        .pass             (pass4),
        .err_cnt          (err4),
        .first_fail_vec   (ffvec4),
        .first_fail_valid (ffv4)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [N-1:0] gal(input logic [N-1:0] v);
        return (v >> 1) ^ (v[0] ? TAPS_TB : '0);
    endfunction

    // Vector monitor: APPLY is the first of every 3 busy cycles.
    always @(negedge clk) begin
        if (rst) begin
            phase = 0;
        end else begin
            if (busy) begin
                if (phase == 0) begin
                    if (xq.size() == 0) begin
                        fail_now("x_unexpected");
                    end else begin
                        xe = xq.pop_front();
                        chk("x", x, xe);
                    end
                end
                phase = (phase == 2) ? 0 : phase + 1;
            end else begin
                phase = 0;
            end
            if (done) begin
                if (resq.size() == 0) begin
                    fail_now("done_unexpected");
                end else begin
                    rm = resq.pop_front();
                    chk("done_cyc", cyc, rm.cyc);
                    chk("busy_in_done", busy, 0);
                    chk("pass", pass, rm.pass);
                    chk("err_cnt", err_cnt, rm.err);
                    chk("ff_valid", ffv, rm.ffv);
                    if (rm.ffv) chk("ff_vec", ffvec, rm.ffvec);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done4) begin
            if (res4q.size() == 0) begin
                fail_now("done4_unexpected");
            end else begin
                rm4 = res4q.pop_front();
                chk("done4_cyc", cyc, rm4.cyc);
                chk("pass4", pass4, rm4.pass);
                chk("err4", err4, rm4.err);
                chk("ff_valid4", ffv4, rm4.ffv);
                chk("ff_vec4", ffvec4, rm4.ffvec);
            end
        end
    end

    task automatic run(input bit m, input int nv,
                       input logic [N-1:0] sd, input int mdl,
                       input bit ep, input int ee, input bit ev,
                       input logic [N-1:0] efv);
        res_t r;
        logic [N-1:0] v;
        @(negedge clk);
        model   = mdl;
        mode    = m;
        num_vec = nv;
        seed    = sd;
        start   = 1'b1;
        r.cyc   = cyc + nv * 3 + 1;
        r.pass  = ep;
        r.err   = ee;
        r.ffv   = ev;
        r.ffvec = efv;
        resq.push_back(r);
        v = (m && sd == '0) ? 53'd1 : sd;
        for (int i = 0; i < nv; i++) begin
            xq.push_back(v);
            v = m ? gal(v) : v + 53'd1;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int i;
        for (i = 0; i < lim; i++) begin
            @(negedge clk);
            if (resq.size() == 0 && !busy && !done) break;
        end
        if (i == lim) fail_now("timeout");
        chk("x_left", xq.size(), 0);
        xq.delete();
        resq.delete();
    endtask

    initial begin
        res_t r4;
        int i;
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        num_vec  = '0;
        seed     = '0;
        model    = 0;
        start4   = 1'b0;
        num_vec4 = '0;
        seed4    = '0;
        repeat (3) @(negedge clk);
        chk("rst_x", x, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_ffv", ffv, 0);
        chk("rst_ffvec", ffvec, 0);
        rst = 1'b0;
        @(negedge clk);

        // exhaustive 0..15, correct gate
        run(0, 16, 53'd0, 0, 1, 0, 0, 53'd0);
        wait_idle(200);
        // faulty >=26 gate on a 26-ones vector
        run(0, 2, 53'h3FF_FFFF, 1, 0, 1, 1, 53'h3FF_FFFF);
        wait_idle(100);
        // zero-length run clears a failing result
        run(0, 0, 53'h123, 0, 1, 0, 0, 53'd0);
        wait_idle(50);
        // wrap at 2^53; refs 1,1,0
        run(0, 3, 53'h1F_FFFF_FFFF_FFFE, 0, 1, 0, 0, 53'd0);
        wait_idle(100);
        run(0, 3, 53'h1F_FFFF_FFFF_FFFE, 2, 0, 1, 1, 53'd0);
        wait_idle(100);
        // LFSR from zero seed
        run(1, 1000, 53'd0, 0, 1, 0, 0, 53'd0);
        wait_idle(3200);

        // start mid-run is ignored
        run(0, 5, 53'd100, 0, 1, 0, 0, 53'd0);
        repeat (4) @(negedge clk);
        mode    = 1'b1;
        num_vec = 7;
        seed    = 53'd9;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_idle(100);

        // reset at cycle 10 of a failing run
        run(0, 16, 53'd5, 2, 0, 0, 0, 53'd0);
        repeat (9) @(negedge clk);
        chk("pre_rst_err", err_cnt, 3);
        chk("pre_rst_ffvec", ffvec, 5);
        rst = 1'b1;
        @(negedge clk);
        chk("rst10_x", x, 0);
        chk("rst10_busy", busy, 0);
        chk("rst10_done", done, 0);
        chk("rst10_pass", pass, 0);
        chk("rst10_err", err_cnt, 0);
        chk("rst10_ffv", ffv, 0);
        chk("rst10_ffvec", ffvec, 0);
        xq.delete();
        resq.delete();
        rst = 1'b0;
        @(negedge clk);
        run(0, 4, 53'd100, 0, 1, 0, 0, 53'd0);
        wait_idle(100);

        // 4-bit saturating counter, stuck-at-1 gate, no settle
        @(negedge clk);
        seed4    = '0;
        num_vec4 = 20;
        start4   = 1'b1;
        r4.cyc   = cyc + 20 * 2 + 1;
        r4.pass  = 1'b0;
        r4.err   = 15;
        r4.ffv   = 1'b1;
        r4.ffvec = '0;
        res4q.push_back(r4);
        @(negedge clk);
        start4 = 1'b0;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (res4q.size() == 0 && !busy4 && !done4) break;
        end
        if (i == 200) fail_now("timeout4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maj_bist_engine.md
# maj_bist_engine

Self-test engine for the N-input majority/threshold gates produced by the folded bias-decomposition flow. It is the driving and checking side of a combinational `top` netlist: it generates input vectors on `x`, samples the netlist's `y0` after a programmable settle time, and compares each sample against an internal popcount threshold reference. It accumulates a mismatch count and captures the first failing vector, so mapped gates can be checked on silicon or FPGA without a simulator-side sweep.

## Interface
- `N`, 53: DUT input width.
- `THRESH`, 27: reference output is 1 when popcount(x) ≥ `THRESH`.
- `CNT_W`, 32: width of the vector-count register.
- `MISS_W`, 16: width of the mismatch counter, which saturates.
- `SETTLE`, 1: number of WAIT cycles between applying `x` and sampling `y_dut`. Legal range is 0..255.
- `TAPS`, `maj_bist_pkg::TAPS53`: Galois LFSR feedback mask, N bits wide. The 53-bit default implements taps 53, 52, 38, 37.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: starts a run. Accepted only in IDLE.
- `mode` in 1: 0 selects exhaustive (increment), 1 selects LFSR. Sampled when `start` is accepted.
- `num_vec` in `CNT_W`: number of vectors to apply. Sampled when `start` is accepted.
- `seed` in N: first vector. Sampled when `start` is accepted.
- `x` out N: drives DUT inputs x0..x{N-1}. Registered.
- `y_dut` in 1: DUT output `y0`.
- `busy` out 1: high from APPLY through CHECK.
- `done` out 1: one-cycle pulse in DONE.
- `pass` out 1: 1 if `err_cnt == 0`. Valid once `done` has pulsed.
- `err_cnt` out `MISS_W`: saturating mismatch count.
- `first_fail_vec` out N: first vector whose sample mismatched.
- `first_fail_valid` out 1: `first_fail_vec` holds a captured vector.

## Operation
- The FSM states are IDLE, APPLY, WAIT, CHECK, DONE.
- **IDLE**
  - With `start=1`, the engine latches `mode`, `num_vec` and `seed` and clears `err_cnt`, `first_fail_valid` and `pass`.
  - If `num_vec == 0` it goes to DONE. Otherwise it loads `x` with the seed and goes to APPLY.
  - In LFSR mode an all-zero seed is replaced by 1.
- **APPLY**
  - `x` is held.
  - `ref_q` is registered as (popcount(x) ≥ `THRESH`). The popcount sum is ceil(log2(N+1)) bits wide, 6 bits for N=53.
  - Goes to WAIT, or directly to CHECK when `SETTLE == 0`.
- **WAIT**: counts `SETTLE` cycles, then goes to CHECK.
- **CHECK**
  - If `y_dut != ref_q`:
    - `err_cnt` increments, stopping at all-ones.
    - If `first_fail_valid` is still 0, the engine captures `x` into `first_fail_vec` and sets `first_fail_valid`.
  - The remaining-vector count decrements.
  - If the count reaches 0, the engine goes to DONE.
  - Otherwise it advances `x` and goes to APPLY:
    - Exhaustive mode: `x + 1`, wrapping modulo 2^N.
    - LFSR mode: Galois shift right; when the LSB is 1, XOR with `TAPS`.
- **DONE**: `done=1` and `busy=0`. `pass` is set to (`err_cnt == 0`). Goes to IDLE.
- Result outputs hold until the next accepted `start`.
- `start` is ignored in every state other than IDLE.
- `rst` at any point, including mid-run, forces:
  - state IDLE;
  - `x` = 0;
  - `busy`, `done`, `pass`, `err_cnt`, `first_fail_valid` and `first_fail_vec` all 0.

## Timing
- Take cycle 0 as the IDLE cycle in which `start` is accepted.
- Each vector occupies `SETTLE` + 2 cycles: APPLY at cycle 1 + k·(`SETTLE`+2), and CHECK at (k+1)·(`SETTLE`+2).
- `x` changes only on the transition from CHECK to APPLY, which gives the DUT `SETTLE` + 1 full cycles before sampling.
- `done` pulses at cycle `num_vec`·(`SETTLE`+2) + 1, or at cycle 1 when `num_vec == 0`.
- `err_cnt` updates one cycle after CHECK.
- `y_dut` is sampled only in CHECK.

## Structure
- `maj_bist_pkg` holds:
  - the state enum;
  - the `popcount` function, parameterised by width;
  - `TAPS53` and the other width-specific LFSR tap constants.
- One sub-module, `maj_bist_vecgen`: the x register with increment/LFSR step, seed load and zero-seed substitution.
- The FSM, reference logic and checker live in `maj_bist_engine`.

## Test plan
Defaults apply unless stated. "Correct model" is the DUT model y = popcount ≥ 27.
1. Exhaustive, seed 0, `num_vec` = 16, correct model:
   - `x` steps 0..15;
   - `done` at cycle 49;
   - `pass=1`, `err_cnt=0`, `first_fail_valid=0`.
2. Faulty model y = popcount ≥ 26; exhaustive; seed 0x3FFFFFF (26 ones); `num_vec` = 2:
   - `err_cnt=1`;
   - `first_fail_vec` = 0x3FFFFFF;
   - `pass=0`.
3. Exhaustive, seed 2^53−2, `num_vec` = 3:
   - `x` = 2^53−2, then 2^53−1, then 0;
   - reference values are 1, 1, 0;
   - correct model gives `pass=1`.
4. LFSR mode, seed 0, `num_vec` = 1000, correct model:
   - first `x` = 1, second `x` = `TAPS53`;
   - the sequence matches the bench Galois model;
   - `pass=1`.
5. `MISS_W` = 4, model stuck at 1, exhaustive, seed 0, `num_vec` = 20:
   - all 20 samples mismatch;
   - `err_cnt` = 15 (saturated);
   - `first_fail_vec` = 0.
6. Control cases, each in its own run:
   - `start` pulsed mid-run: ignored.
   - `rst` asserted at cycle 10: all outputs 0 the following cycle, and a new `start` runs cleanly.
   - `num_vec` = 0: `done` at cycle 1 with `pass=1`.
